reg_snapshot_ctrl: RTL and testbench

- Checkpoint/recovery initiator for the register file.
- Captures full register-file images when branches are issued and holds them in an in-order circular buffer of slots.
- On a resolved mispredict, drives the level-sensitive recover_snapshot / regs_snapshot / done / recovery_done_ack handshake that the register file responds to.
- Sits beside reg_file, fed by decode (checkpoint requests), write-back (same-cycle merge) and branch resolution (in EX).

---
 rtl/reg_snapshot_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_reg_snapshot_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_snapshot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_snapshot_ctrl
// Description : Checkpoint/recovery initiator for the register file. Captures
//               full register-file images on branch issue into an in-order
//               circular buffer and, on a resolved mispredict, drives the
//               recover_snapshot / done / recovery_done_ack handshake.
//               Optional macro SNAPSHOT_STATS_EN adds recovery and stall
//               statistics counters (stat_recoveries, stat_stall_cycles).
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module reg_snapshot_ctrl #(
    parameter int NUM_CKPT = 4,
    parameter int ID_W     = $clog2(NUM_CKPT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ckpt_req,
    output logic                          ckpt_gnt,
    output logic [ID_W-1:0]               ckpt_id,
    output logic                          full,
    input  logic [31:0][`DATA_WIDTH-1:0]  regs_in,
    input  logic                          wb_uses_rw,
    input  logic [4:0]                    wb_rw_addr,
    input  logic [`DATA_WIDTH-1:0]        wb_rw_data,
    input  logic                          resolve_valid,
    input  logic [ID_W-1:0]               resolve_id,
    input  logic                          resolve_mispredict,
    output logic                          recover_snapshot,
    output logic [31:0][`DATA_WIDTH-1:0]  regs_snapshot,
    input  logic                          done,
    output logic                          recovery_done_ack,
    output logic                          busy,
    output logic                          order_err
`ifdef SNAPSHOT_STATS_EN
    ,
    output logic [31:0]                   stat_recoveries,
    output logic [31:0]                   stat_stall_cycles
`endif
);

    localparam int              c_DW    = `DATA_WIDTH;
    localparam int              c_CNT_W = ID_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(NUM_CKPT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECOVER = 2'd1,
        S_ACK     = 2'd2
    } state_t;

    state_t                     r_state;
    logic [ID_W-1:0]            r_head;
    logic [ID_W-1:0]            r_tail;
    logic [c_CNT_W-1:0]         r_count;
    logic                       r_order_err;
    logic [31:0][c_DW-1:0]      r_snapshot;
    logic [31:0][c_DW-1:0]      r_slot [NUM_CKPT];

    logic                       w_idle;
    logic                       w_resolve;
    logic                       w_order_bad;
    logic                       w_mispredict;
    logic                       w_correct;
    logic                       w_gnt;
    logic [31:0][c_DW-1:0]      w_capture;

    // Resolution decode: only honoured in IDLE, and only for the oldest live slot
    assign w_idle       = (r_state == S_IDLE);
    assign w_resolve    = resolve_valid & w_idle;
    assign w_order_bad  = w_resolve & ((resolve_id != r_head) | (r_count == '0));
    assign w_mispredict = w_resolve & ~w_order_bad & resolve_mispredict;
    assign w_correct    = w_resolve & ~w_order_bad & ~resolve_mispredict;

    // A mispredict flushes the buffer, so a grant in the same cycle is dropped
    assign w_gnt     = ckpt_req & ~full & w_idle & ~w_mispredict;
    assign ckpt_gnt  = w_gnt;
    assign ckpt_id   = r_tail;
    assign full      = (r_count == c_FULL);
    assign busy      = ~w_idle;
    assign order_err = r_order_err;
    assign regs_snapshot = r_snapshot;

    // Image to capture: live registers with the concurrent write-back merged, x0 forced to zero
    always_comb begin
        w_capture = regs_in;
        if (wb_uses_rw) begin
            w_capture[wb_rw_addr] = wb_rw_data;
        end
        w_capture[0] = '0;
    end

    // Checkpoint storage; contents are don't-care until written on a grant
    always_ff @(posedge clk) begin
        if (w_gnt) begin
            r_slot[r_tail] <= w_capture;
        end
    end

    // Buffer pointers, occupancy, sticky ordering error and the restore image
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_order_err <= 1'b0;
            r_snapshot  <= '0;
        end else begin
            if (w_order_bad) begin
                r_order_err <= 1'b1;
            end
            if (w_mispredict) begin
                r_snapshot <= r_slot[r_head];
                r_head     <= r_tail;
                r_count    <= '0;
            end else begin
                if (w_gnt) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_correct) begin
                    r_head <= r_head + 1'b1;
                end
                case ({w_gnt, w_correct})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Recovery handshake FSM with registered request/acknowledge outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= S_IDLE;
            recover_snapshot  <= 1'b0;
            recovery_done_ack <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    recovery_done_ack <= 1'b0;
                    if (w_mispredict) begin
                        r_state          <= S_RECOVER;
                        recover_snapshot <= 1'b1;
                    end
                end
                S_RECOVER: begin
                    if (done) begin
                        r_state           <= S_ACK;
                        recover_snapshot  <= 1'b0;
                        recovery_done_ack <= 1'b1;
                    end
                end
                S_ACK: begin
                    if (!done) begin
                        r_state           <= S_IDLE;
                        recovery_done_ack <= 1'b0;
                    end
                end
                default: begin
                    r_state           <= S_IDLE;
                    recover_snapshot  <= 1'b0;
                    recovery_done_ack <= 1'b0;
                end
            endcase
        end
    end

`ifdef SNAPSHOT_STATS_EN
    logic [31:0] r_stat_recoveries;
    logic [31:0] r_stat_stall_cycles;

    assign stat_recoveries   = r_stat_recoveries;
    assign stat_stall_cycles = r_stat_stall_cycles;

    // Saturating counters of recoveries started and of front-end stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_recoveries   <= '0;
            r_stat_stall_cycles <= '0;
        end else begin
            if (w_mispredict && (r_stat_recoveries != '1)) begin
                r_stat_recoveries <= r_stat_recoveries + 1'b1;
            end
            if ((busy || (ckpt_req && full)) && (r_stat_stall_cycles != '1)) begin
                r_stat_stall_cycles <= r_stat_stall_cycles + 1'b1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_snapshot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_snapshot_ctrl
// Description : Directed self-checking bench for reg_snapshot_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_reg_snapshot_ctrl;

    localparam int NUM_CKPT = 4;
    localparam int ID_W     = 2;
    localparam int DW       = `DATA_WIDTH;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   ckpt_req;
    logic                   ckpt_gnt;
    logic [ID_W-1:0]        ckpt_id;
    logic                   full;
    logic [31:0][DW-1:0]    regs_in;
    logic                   wb_uses_rw;
    logic [4:0]             wb_rw_addr;
    logic [DW-1:0]          wb_rw_data;
    logic                   resolve_valid;
    logic [ID_W-1:0]        resolve_id;
    logic                   resolve_mispredict;
    logic                   recover_snapshot;
    logic [31:0][DW-1:0]    regs_snapshot;
    logic                   done;
    logic                   recovery_done_ack;
    logic                   busy;
    logic                   order_err;
`ifdef SNAPSHOT_STATS_EN
    logic [31:0]            stat_recoveries;
    logic [31:0]            stat_stall_cycles;
`endif

    int n_vec = 0;
    int n_err = 0;

    reg_snapshot_ctrl #(.NUM_CKPT(NUM_CKPT), .ID_W(ID_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .ckpt_req           (ckpt_req),
        .ckpt_gnt           (ckpt_gnt),
        .ckpt_id            (ckpt_id),
        .full               (full),
        .regs_in            (regs_in),
        .wb_uses_rw         (wb_uses_rw),
        .wb_rw_addr         (wb_rw_addr),
        .wb_rw_data         (wb_rw_data),
        .resolve_valid      (resolve_valid),
        .resolve_id         (resolve_id),
        .resolve_mispredict (resolve_mispredict),
        .recover_snapshot   (recover_snapshot),
        .regs_snapshot      (regs_snapshot),
        .done               (done),
        .recovery_done_ack  (recovery_done_ack),
        .busy               (busy),
        .order_err          (order_err)
`ifdef SNAPSHOT_STATS_EN
        ,
        .stat_recoveries    (stat_recoveries),
        .stat_stall_cycles  (stat_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        ckpt_req           = 1'b0;
        regs_in            = '0;
        wb_uses_rw         = 1'b0;
        wb_rw_addr         = '0;
        wb_rw_data         = '0;
        resolve_valid      = 1'b0;
        resolve_id         = '0;
        resolve_mispredict = 1'b0;
        done               = 1'b0;
    endtask

    task automatic pulse_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Called one step after the mispredict edge; reg_file answers one cycle later
    task automatic run_recovery(input logic [DW-1:0] exp5, input logic exp_err,
                                input logic [ID_W-1:0] exp_tail);
        n_vec++; if (recover_snapshot !== 1'b1 || recovery_done_ack !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL rec_enter: rs=%0b ack=%0b busy=%0b expected 1 0 1", recover_snapshot, recovery_done_ack, busy); end
        n_vec++; if (regs_snapshot[5] !== exp5) begin
            n_err++; $display("FAIL rec_snap5: got %h expected %h", regs_snapshot[5], exp5); end
        ckpt_req = 1'b1; resolve_valid = 1'b1; resolve_id = exp_tail + 2'd1; resolve_mispredict = 1'b0;
        #1;
        n_vec++; if (ckpt_gnt !== 1'b0) begin
            n_err++; $display("FAIL rec_gnt_ignored: got %0b expected 0", ckpt_gnt); end
        done = 1'b1;
        tick();
        n_vec++; if (recover_snapshot !== 1'b0 || recovery_done_ack !== 1'b1 || busy !== 1'b1) begin
            n_err++; $display("FAIL rec_ack1: rs=%0b ack=%0b busy=%0b expected 0 1 1", recover_snapshot, recovery_done_ack, busy); end
        tick();
        n_vec++; if (recovery_done_ack !== 1'b1 || busy !== 1'b1 || regs_snapshot[5] !== exp5) begin
            n_err++; $display("FAIL rec_ack2: ack=%0b busy=%0b snap5=%h expected 1 1 %h", recovery_done_ack, busy, regs_snapshot[5], exp5); end
        ckpt_req = 1'b0; resolve_valid = 1'b0; done = 1'b0;
        tick();
        n_vec++; if (busy !== 1'b0 || recovery_done_ack !== 1'b0 || recover_snapshot !== 1'b0) begin
            n_err++; $display("FAIL rec_exit: busy=%0b ack=%0b rs=%0b expected 0 0 0", busy, recovery_done_ack, recover_snapshot); end
        n_vec++; if (order_err !== exp_err || ckpt_id !== exp_tail || full !== 1'b0) begin
            n_err++; $display("FAIL rec_state: err=%0b id=%0d full=%0b expected %0b %0d 0", order_err, ckpt_id, full, exp_err, exp_tail); end
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_vec++; if (recover_snapshot !== 1'b0 || recovery_done_ack !== 1'b0 || busy !== 1'b0 || full !== 1'b0 || order_err !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: rs=%0b ack=%0b busy=%0b full=%0b err=%0b expected all 0",
                              recover_snapshot, recovery_done_ack, busy, full, order_err); end
        n_vec++; if (ckpt_gnt !== 1'b0 || ckpt_id !== 2'd0 || regs_snapshot !== '0) begin
            n_err++; $display("FAIL reset_data: gnt=%0b id=%0d snap_nonzero=%0b expected 0 0 0", ckpt_gnt, ckpt_id, regs_snapshot != '0); end
        rst = 1'b0;
    endtask

    task automatic test_fill;
        for (int i = 0; i < 4; i++) begin
            regs_in[5] = DW'(i + 1);
            ckpt_req = 1'b1;
            #1;
            n_vec++; if (ckpt_gnt !== 1'b1 || ckpt_id !== ID_W'(i)) begin
                n_err++; $display("FAIL fill_gnt%0d: gnt=%0b id=%0d expected 1 %0d", i, ckpt_gnt, ckpt_id, i); end
            tick();
        end
        n_vec++; if (full !== 1'b1) begin
            n_err++; $display("FAIL fill_full: got %0b expected 1", full); end
        regs_in[5] = 'h9;
        #1;
        n_vec++; if (ckpt_gnt !== 1'b0) begin
            n_err++; $display("FAIL fill_fifth_gnt: got %0b expected 0", ckpt_gnt); end
        tick();
        n_vec++; if (full !== 1'b1 || ckpt_id !== 2'd0) begin
            n_err++; $display("FAIL fill_hold: full=%0b id=%0d expected 1 0", full, ckpt_id); end
        ckpt_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            resolve_valid = 1'b1; resolve_id = ID_W'(i); resolve_mispredict = 1'b0;
            tick();
            if (i == 0) begin
                n_vec++; if (full !== 1'b0) begin
                    n_err++; $display("FAIL fill_drain_full: got %0b expected 0", full); end
            end
        end
        resolve_valid = 1'b1; resolve_id = 2'd3; resolve_mispredict = 1'b1;
        tick();
        clear_inputs();
        run_recovery('h4, 1'b0, 2'd0);
    endtask

    task automatic test_wb_merge;
        clear_inputs();
        regs_in[7] = 'h1; regs_in[0] = 'h55; regs_in[3] = 'h33;
        wb_uses_rw = 1'b1; wb_rw_addr = 5'd7; wb_rw_data = 'hDEAD;
        ckpt_req = 1'b1;
        #1;
        n_vec++; if (ckpt_gnt !== 1'b1 || ckpt_id !== 2'd0) begin
            n_err++; $display("FAIL wb_gnt: gnt=%0b id=%0d expected 1 0", ckpt_gnt, ckpt_id); end
        tick();
        ckpt_req = 1'b0;
        regs_in[3] = 'h99; wb_rw_addr = 5'd3; wb_rw_data = 'hBEEF;
        resolve_valid = 1'b1; resolve_id = 2'd0; resolve_mispredict = 1'b1;
        tick();
        clear_inputs();
        n_vec++; if (regs_snapshot[7] !== DW'('hDEAD) || regs_snapshot[0] !== '0) begin
            n_err++; $display("FAIL wb_merge: r7=%h r0=%h expected dead 0", regs_snapshot[7], regs_snapshot[0]); end
        n_vec++; if (regs_snapshot[3] !== DW'('h33)) begin
            n_err++; $display("FAIL wb_no_slot_update: r3=%h expected 33", regs_snapshot[3]); end
        run_recovery('h0, 1'b0, 2'd1);
    endtask

    task automatic test_recovery;
        regs_in[5] = 'h11; ckpt_req = 1'b1;
        #1;
        n_vec++; if (ckpt_id !== 2'd1) begin
            n_err++; $display("FAIL recov_id1: got %0d expected 1", ckpt_id); end
        tick();
        regs_in[5] = 'h22;
        #1;
        n_vec++; if (ckpt_id !== 2'd2) begin
            n_err++; $display("FAIL recov_id2: got %0d expected 2", ckpt_id); end
        tick();
        ckpt_req = 1'b0;
        resolve_valid = 1'b1; resolve_id = 2'd1; resolve_mispredict = 1'b0;
        tick();
        n_vec++; if (order_err !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL recov_correct: err=%0b busy=%0b expected 0 0", order_err, busy); end
        resolve_id = 2'd2; resolve_mispredict = 1'b1;
        tick();
        clear_inputs();
        run_recovery('h22, 1'b0, 2'd3);
    endtask

    task automatic test_order_err;
        pulse_reset();
        regs_in[5] = 'hA0; ckpt_req = 1'b1; tick();
        regs_in[5] = 'hA1; tick();
        ckpt_req = 1'b0;
        resolve_valid = 1'b1; resolve_id = 2'd1; resolve_mispredict = 1'b0;
        tick();
        resolve_valid = 1'b0;
        n_vec++; if (order_err !== 1'b1) begin
            n_err++; $display("FAIL order_err_set: got %0b expected 1", order_err); end
        regs_in[5] = 'hA2; ckpt_req = 1'b1;
        resolve_valid = 1'b1; resolve_id = 2'd0; resolve_mispredict = 1'b0;
        #1;
        n_vec++; if (ckpt_gnt !== 1'b1 || ckpt_id !== 2'd2) begin
            n_err++; $display("FAIL order_same_cycle: gnt=%0b id=%0d expected 1 2", ckpt_gnt, ckpt_id); end
        tick();
        resolve_valid = 1'b0;
        regs_in[5] = 'hA3;
        #1;
        n_vec++; if (ckpt_gnt !== 1'b1 || ckpt_id !== 2'd3) begin
            n_err++; $display("FAIL order_gnt3: gnt=%0b id=%0d expected 1 3", ckpt_gnt, ckpt_id); end
        tick();
        n_vec++; if (full !== 1'b0) begin
            n_err++; $display("FAIL order_count3: full=%0b expected 0", full); end
        regs_in[5] = 'hA4;
        tick();
        ckpt_req = 1'b0;
        n_vec++; if (full !== 1'b1 || order_err !== 1'b1) begin
            n_err++; $display("FAIL order_count4: full=%0b err=%0b expected 1 1", full, order_err); end
        resolve_valid = 1'b1; resolve_id = 2'd1; resolve_mispredict = 1'b1;
        tick();
        clear_inputs();
        n_vec++; if (recover_snapshot !== 1'b1 || regs_snapshot[5] !== DW'('hA1)) begin
            n_err++; $display("FAIL order_mispredict: rs=%0b snap5=%h expected 1 a1", recover_snapshot, regs_snapshot[5]); end
    endtask

    task automatic test_reset_mid_recovery;
        rst = 1'b1;
        done = 1'b1;
        tick();
        rst = 1'b0;
        done = 1'b0;
        n_vec++; if (recover_snapshot !== 1'b0 || recovery_done_ack !== 1'b0 || busy !== 1'b0 || full !== 1'b0 || order_err !== 1'b0) begin
            n_err++; $display("FAIL midrst_flags: rs=%0b ack=%0b busy=%0b full=%0b err=%0b expected all 0",
                              recover_snapshot, recovery_done_ack, busy, full, order_err); end
        n_vec++; if (regs_snapshot !== '0) begin
            n_err++; $display("FAIL midrst_snapshot: nonzero=%0b expected 0", regs_snapshot != '0); end
        ckpt_req = 1'b1;
        #1;
        n_vec++; if (ckpt_gnt !== 1'b1 || ckpt_id !== 2'd0) begin
            n_err++; $display("FAIL midrst_gnt: gnt=%0b id=%0d expected 1 0", ckpt_gnt, ckpt_id); end
        tick();
        ckpt_req = 1'b0;
        resolve_valid = 1'b1; resolve_id = 2'd0; resolve_mispredict = 1'b0;
        tick();
        n_vec++; if (order_err !== 1'b0) begin
            n_err++; $display("FAIL empty_pre: err=%0b expected 0", order_err); end
        resolve_id = 2'd1;
        tick();
        resolve_valid = 1'b0;
        n_vec++; if (order_err !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL empty_resolve: err=%0b busy=%0b expected 1 0", order_err, busy); end
    endtask

    task automatic test_gnt_vs_mispredict;
        pulse_reset();
        regs_in[5] = 'hC0; ckpt_req = 1'b1;
        tick();
        regs_in[5] = 'hC1;
        resolve_valid = 1'b1; resolve_id = 2'd0; resolve_mispredict = 1'b1;
        #1;
        n_vec++; if (ckpt_gnt !== 1'b0) begin
            n_err++; $display("FAIL gnt_vs_misp: gnt=%0b expected 0", ckpt_gnt); end
        tick();
        clear_inputs();
        run_recovery('hC0, 1'b0, 2'd1);
    endtask

`ifdef SNAPSHOT_STATS_EN
    task automatic test_stats;
        pulse_reset();
        regs_in[5] = 'hD0; ckpt_req = 1'b1; tick();
        ckpt_req = 1'b0;
        resolve_valid = 1'b1; resolve_id = 2'd0; resolve_mispredict = 1'b1; tick();
        clear_inputs();
        run_recovery('hD0, 1'b0, 2'd1);
        regs_in[5] = 'hD1; ckpt_req = 1'b1; tick();
        ckpt_req = 1'b0;
        resolve_valid = 1'b1; resolve_id = 2'd1; resolve_mispredict = 1'b1; tick();
        clear_inputs();
        run_recovery('hD1, 1'b0, 2'd2);
        n_vec++; if (stat_recoveries !== 32'd2 || stat_stall_cycles !== 32'd6) begin
            n_err++; $display("FAIL stats: rec=%0d stall=%0d expected 2 6", stat_recoveries, stat_stall_cycles); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_fill();
        test_wb_merge();
        test_recovery();
        test_order_err();
        test_reset_mid_recovery();
        test_gnt_vs_mispredict();
`ifdef SNAPSHOT_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
